dbgu32_cmd: RTL and testbench
=============================

# dbgu32_cmd

Command responder of the 32-bit debug unit: consumes the host byte stream delivered by the debug UART receiver and decodes it into pointer loads, bus reads/writes and CPU clock control. It sits between the debug UART (RX/TX byte ports) and the SoC memory bus, acting as a picorv32-style bus master. Read data is returned to the host through the UART transmitter.

## Interface
- No parameters; all widths fixed (32-bit address/data, 8-bit bytes).
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte, valid when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  transmitter accepts tx_data this cycle
- mem_valid  out  1  bus request
- mem_ready  in  1  bus completion
- mem_addr  out  32  word address, {ptr[31:2],2'b00}
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'hF for write, 4'h0 for read
- mem_rdata  in  32  read data, sampled when mem_ready=1
- cpu_clk_en  out  1  CPU clock enable
- overrun  out  1  one-cycle pulse: rx byte dropped while busy

## Operation
- Commands (opcode byte, then little-endian argument bytes):
  - 0x01 + 4 bytes: ptr <= argument.
  - 0x04 + 4 bytes: write argument word to mem[ptr], then ptr += 4.
  - 0x05: read mem[ptr], send 4 bytes LSB first, then ptr += 4.
  - 0x22 + 1 byte: cpu_clk_en <= byte[0].
  - Any other opcode: ignored, stay IDLE, no response.
- States: IDLE -> ARG (opcode 01/04/22) or MEM_RD (05); ARG collects bytes with 3-bit counter into shift register (byte k -> bits 8k+7:8k); on last byte: 01 -> IDLE, 22 -> IDLE, 04 -> MEM_WR; MEM_WR/MEM_RD assert mem_valid until mem_ready; MEM_WR -> IDLE; MEM_RD latches mem_rdata -> TX; TX presents 4 bytes, advancing on tx_valid&tx_ready; after byte 3 -> IDLE.
- ptr increments modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000); ptr[1:0] kept but not driven on bus.
- rx_valid in MEM_WR, MEM_RD or TX: byte dropped, overrun pulses next cycle, state unaffected.
- Bus access is independent of cpu_clk_en; the arbiter is outside this block.

## Timing
- Reset values: state IDLE, ptr 0, tx_valid 0, tx_data 0, mem_valid 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, cpu_clk_en 1, overrun 0.
- mem_valid rises the cycle after the last argument byte (04) or opcode (05); falls the cycle after mem_ready; mem_addr/wdata/wstrb stable while mem_valid=1.
- ptr update occurs in the same cycle mem_valid falls.
- tx_valid rises the cycle after mem_ready for reads; tx_data never changes while tx_valid=1 and tx_ready=0.
- cpu_clk_en and ptr (cmd 01) update the cycle after the final argument byte strobe.
- RESET asserted mid-command or mid-bus-cycle: immediate return to reset values; partial arguments discarded; mem_valid drops asynchronously.

## Structure
- Shared package/header: opcode constants (CMD_SET_PTR=0x01, CMD_WRITE=0x04, CMD_READ=0x05, CMD_CLK=0x22) and state encodings, reused by host-side tools and benches.
- Single module; no sub-module needed. UART RX/TX are external and instantiated by the debug-unit top.

## Test plan
- Send 01 00 00 02 00 -> ptr=0x00020000, no bus activity, no TX.
- Then 04 DD CC BB AA -> one write, mem_addr=0x00020000, mem_wdata=0xAABBCCDD, wstrb=F; ptr=0x00020004.
- Then 04 80 AA 80 AA, 01 00 00 02 00, 05, 05 -> writes 0xAA80AA80 at 0x00020004; reads return bytes DD CC BB AA then 80 AA 80 AA; final ptr=0x00020008.
- Send 22 00 -> cpu_clk_en=0; 22 01 -> 1; opcode 0x7F followed by 05 -> 0x7F ignored, 05 performs read.
- Hold tx_ready=0 for 50 cycles during read reply and inject rx byte -> tx_data stable, overrun pulses once, byte lost, state resumes.
- Assert RESET after 2 argument bytes of cmd 01 and during mem_valid with mem_ready low -> all outputs to reset values, next full command decodes correctly; ptr 0xFFFFFFFC + read -> ptr wraps to 0.

Source files
------------

// File: rtl/dbgu32_cmd_pkg.sv
// Shared definitions for the debug-unit command responder: host opcodes,
// FSM state encoding and small byte helpers.
package dbgu32_cmd_pkg;

   localparam logic [7:0] CMD_SET_PTR = 8'h01;
   localparam logic [7:0] CMD_WRITE   = 8'h04;
   localparam logic [7:0] CMD_READ    = 8'h05;
   localparam logic [7:0] CMD_CLK     = 8'h22;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARG    = 3'd1,
      ST_MEM_WR = 3'd2,
      ST_MEM_RD = 3'd3,
      ST_TX     = 3'd4
   } state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } bus_req_t;

   // Index of the final argument byte for opcodes that take arguments.
   function automatic logic [2:0] arg_last(input logic [7:0] op);
      return (op == CMD_CLK) ? 3'd0 : 3'd3;
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/dbgu32_cmd.sv
// Debug-unit command responder: decodes the host byte stream into pointer
// loads, bus reads/writes and CPU clock control; read data goes back over TX.
module dbgu32_cmd
   import dbgu32_cmd_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic        cpu_clk_en,
   output logic        overrun
);

   state_e      state_q, state_d;
   logic [7:0]  op_q, op_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] arg_q, arg_d, arg_nxt;
   logic [31:0] ptr_q, ptr_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  txi_q, txi_d;
   bus_req_t    req_q, req_d;
   logic        mem_valid_q, mem_valid_d;
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        clk_en_q, clk_en_d;
   logic        overrun_q, overrun_d;
   logic [31:0] word_addr;

   assign word_addr = {ptr_q[31:2], 2'b00};

   // Argument word with the incoming byte dropped into its little-endian slot.
   always_comb begin
      arg_nxt = arg_q;
      case (cnt_q[1:0])
         2'd0:    arg_nxt[7:0]   = rx_data;
         2'd1:    arg_nxt[15:8]  = rx_data;
         2'd2:    arg_nxt[23:16] = rx_data;
         default: arg_nxt[31:24] = rx_data;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      arg_d       = arg_q;
      ptr_d       = ptr_q;
      rdata_d     = rdata_q;
      txi_d       = txi_q;
      req_d       = req_q;
      mem_valid_d = mem_valid_q;
      tx_valid_d  = tx_valid_q;
      tx_data_d   = tx_data_q;
      clk_en_d    = clk_en_q;
      overrun_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (rx_valid) begin
               op_d  = rx_data;
               cnt_d = 3'd0;
               case (rx_data)
                  CMD_SET_PTR, CMD_WRITE, CMD_CLK: state_d = ST_ARG;
                  CMD_READ: begin
                     state_d     = ST_MEM_RD;
                     mem_valid_d = 1'b1;
                     req_d.addr  = word_addr;
                     req_d.wstrb = 4'h0;
                  end
                  default: ;
               endcase
            end
         end

         ST_ARG: begin
            if (rx_valid) begin
               arg_d = arg_nxt;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == arg_last(op_q)) begin
                  state_d = ST_IDLE;
                  case (op_q)
                     CMD_SET_PTR: ptr_d = arg_nxt;
                     CMD_CLK:     clk_en_d = rx_data[0];
                     CMD_WRITE: begin
                        state_d     = ST_MEM_WR;
                        mem_valid_d = 1'b1;
                        req_d.addr  = word_addr;
                        req_d.wdata = arg_nxt;
                        req_d.wstrb = 4'hF;
                     end
                     default: ;
                  endcase
               end
            end
         end

         ST_MEM_WR, ST_MEM_RD: begin
            overrun_d = rx_valid;
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               ptr_d       = ptr_q + 32'd4;
               if (state_q == ST_MEM_RD) begin
                  rdata_d    = mem_rdata;
                  tx_valid_d = 1'b1;
                  tx_data_d  = mem_rdata[7:0];
                  txi_d      = 2'd0;
                  state_d    = ST_TX;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         ST_TX: begin
            overrun_d = rx_valid;
            if (tx_ready) begin
               if (txi_q == 2'd3) begin
                  tx_valid_d = 1'b0;
                  state_d    = ST_IDLE;
               end else begin
                  txi_d     = txi_q + 2'd1;
                  tx_data_d = byte_sel(rdata_q, txi_q + 2'd1);
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= ST_IDLE;
         op_q        <= 8'h00;
         cnt_q       <= 3'd0;
         arg_q       <= 32'h0;
         ptr_q       <= 32'h0;
         rdata_q     <= 32'h0;
         txi_q       <= 2'd0;
         req_q       <= '0;
         mem_valid_q <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         clk_en_q    <= 1'b1;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         arg_q       <= arg_d;
         ptr_q       <= ptr_d;
         rdata_q     <= rdata_d;
         txi_q       <= txi_d;
         req_q       <= req_d;
         mem_valid_q <= mem_valid_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         clk_en_q    <= clk_en_d;
         overrun_q   <= overrun_d;
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign mem_valid  = mem_valid_q;
   assign mem_addr   = req_q.addr;
   assign mem_wdata  = req_q.wdata;
   assign mem_wstrb  = req_q.wstrb;
   assign cpu_clk_en = clk_en_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_dbgu32_cmd.sv
// Randomized bench for dbgu32_cmd: host byte driver, bus slave, TX sink and
// a command-level model of pointer, memory and clock-enable state.
module tb_dbgu32_cmd;
   import dbgu32_cmd_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        cpu_clk_en;
   logic        overrun;

   always #5 CLK = ~CLK;

   dbgu32_cmd dut (
      .CLK(CLK), .RESET(RESET),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .cpu_clk_en(cpu_clk_en), .overrun(overrun)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'hC3A5_5A3C;
   endfunction

   // ---------------- bus slave ----------------
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } txn_t;

   txn_t        obs_q[$];
   logic [31:0] slv_mem[logic [31:0]];
   bit          stall_bus = 0;
   int          wait_ctr = 0;
   bit          in_req = 0;
   txn_t        req_start;

   initial begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(posedge CLK); #1;
         if (mem_ready) mem_ready = 1'b0;
         else if (!mem_valid) in_req = 0;
         else begin
            if (!in_req) begin
               in_req    = 1;
               req_start = '{mem_addr, mem_wdata, mem_wstrb};
               wait_ctr  = $urandom_range(0, 3);
            end
            if (!stall_bus) begin
               if (wait_ctr == 0) begin
                  chk("bus_stable", {mem_addr, mem_wdata, mem_wstrb}, req_start);
                  obs_q.push_back('{mem_addr, mem_wdata, mem_wstrb});
                  if (mem_wstrb == 4'hF) slv_mem[mem_addr] = mem_wdata;
                  mem_rdata = slv_mem.exists(mem_addr) ? slv_mem[mem_addr] : dflt(mem_addr);
                  mem_ready = 1'b1;
                  in_req    = 0;
               end else wait_ctr--;
            end
         end
      end
   end

   // ---------------- TX sink / monitors ----------------
   bit         hold_tx = 0;
   logic [7:0] tx_q[$];
   int         ovr_cnt = 0;
   bit         prev_stall = 0;
   logic [7:0] prev_data = 8'h0;

   initial begin
      tx_ready = 1'b0;
      forever begin
         @(posedge CLK); #1;
         tx_ready = hold_tx ? 1'b0 : ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         if (overrun === 1'b1) ovr_cnt++;
         if (prev_stall && tx_valid) chk("tx_hold", tx_data, prev_data);
         if (tx_valid && tx_ready) tx_q.push_back(tx_data);
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   logic [31:0] ptr_m;
   bit          clk_m;
   logic [31:0] mem_m[logic [31:0]];
   int          ovr_exp = 0;

   task automatic tick(input int n);
      repeat (n) begin @(posedge CLK); #2; end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge CLK); #2;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge CLK); #2;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      tick($urandom_range(0, 2));
   endtask

   task automatic wait_bus(output txn_t t, output bit ok);
      t  = '0;
      ok = 0;
      for (int i = 0; i < 300 && obs_q.size() == 0; i++) tick(1);
      if (obs_q.size() == 0) chk("bus_timeout", 0, 1);
      else begin
         t  = obs_q.pop_front();
         ok = 1;
      end
   endtask

   task automatic exp_rd(output logic [31:0] d);
      txn_t t;
      bit ok;
      logic [31:0] a;
      a = {ptr_m[31:2], 2'b00};
      d = mem_m.exists(a) ? mem_m[a] : dflt(a);
      wait_bus(t, ok);
      if (ok) begin
         chk("rd_addr", t.addr, a);
         chk("rd_strb", t.wstrb, 4'h0);
      end
      ptr_m = ptr_m + 32'd4;
   endtask

   task automatic exp_tx(input logic [31:0] d);
      for (int i = 0; i < 600 && tx_q.size() < 4; i++) tick(1);
      if (tx_q.size() < 4) chk("tx_timeout", tx_q.size(), 4);
      else for (int k = 0; k < 4; k++) chk("tx_byte", tx_q.pop_front(), d[8*k +: 8]);
   endtask

   task automatic post_checks();
      tick(4);
      chk("bus_idle", obs_q.size(), 0);
      chk("tx_idle", tx_q.size(), 0);
      chk("clk_en", cpu_clk_en, clk_m);
      chk("ovr_cnt", ovr_cnt, ovr_exp);
      chk("mv_idle", mem_valid, 0);
      chk("tv_idle", tx_valid, 0);
   endtask

   task automatic run_cmd(input logic [7:0] op, input logic [31:0] arg);
      txn_t t;
      bit ok;
      logic [31:0] a, d;
      send_byte(op);
      case (op)
         CMD_SET_PTR: begin
            for (int k = 0; k < 4; k++) send_byte(arg[8*k +: 8]);
            ptr_m = arg;
         end
         CMD_WRITE: begin
            for (int k = 0; k < 4; k++) send_byte(arg[8*k +: 8]);
            a = {ptr_m[31:2], 2'b00};
            wait_bus(t, ok);
            if (ok) begin
               chk("wr_addr", t.addr, a);
               chk("wr_data", t.wdata, arg);
               chk("wr_strb", t.wstrb, 4'hF);
            end
            mem_m[a] = arg;
            ptr_m = ptr_m + 32'd4;
         end
         CMD_READ: begin
            exp_rd(d);
            exp_tx(d);
         end
         CMD_CLK: begin
            send_byte(arg[7:0]);
            clk_m = arg[0];
         end
         default: ;
      endcase
      post_checks();
   endtask

   task automatic do_reset();
      #1;
      RESET = 1'b0;
      #1;
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_wstrb", mem_wstrb, 4'h0);
      chk("rst_clk_en", cpu_clk_en, 1);
      chk("rst_overrun", overrun, 0);
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      ptr_m = 32'h0;
      clk_m = 1;
      tick(2);
   endtask

   logic [7:0]  junk;
   logic [31:0] d;
   int          o0;

   initial begin
      RESET    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      ptr_m    = 32'h0;
      clk_m    = 1;
      #2;
      do_reset();

      // directed sequence
      run_cmd(CMD_SET_PTR, 32'h0002_0000);
      run_cmd(CMD_WRITE, 32'hAABB_CCDD);
      run_cmd(CMD_WRITE, 32'hAA80_AA80);
      run_cmd(CMD_SET_PTR, 32'h0002_0000);
      run_cmd(CMD_READ, 32'h0);
      run_cmd(CMD_READ, 32'h0);
      run_cmd(CMD_WRITE, 32'h1234_5678);   // lands at 0x00020008 iff ptr advanced
      run_cmd(CMD_CLK, 32'h0);
      run_cmd(CMD_CLK, 32'h1);
      run_cmd(8'h7F, 32'h0);
      run_cmd(CMD_READ, 32'h0);

      // TX back-pressure with a byte arriving mid-reply
      hold_tx = 1;
      send_byte(CMD_READ);
      exp_rd(d);
      for (int i = 0; i < 100 && !tx_valid; i++) tick(1);
      chk("tx_up", tx_valid, 1);
      o0 = ovr_cnt;
      send_byte(CMD_READ);
      tick(50);
      chk("ovr_once", ovr_cnt - o0, 1);
      ovr_exp++;
      chk("tx_held", tx_q.size(), 0);
      hold_tx = 0;
      exp_tx(d);
      post_checks();

      // reset in the middle of argument collection
      run_cmd(CMD_SET_PTR, 32'h0000_0400);
      run_cmd(CMD_CLK, 32'h0);
      send_byte(CMD_SET_PTR);
      send_byte(8'hAA);
      send_byte(8'hBB);
      do_reset();
      run_cmd(CMD_READ, 32'h0);
      chk("clk_after_rst", cpu_clk_en, 1);

      // reset while a bus request is stalled
      run_cmd(CMD_SET_PTR, 32'h0000_0800);
      stall_bus = 1;
      send_byte(CMD_READ);
      for (int i = 0; i < 50 && !mem_valid; i++) tick(1);
      chk("stall_mv", mem_valid, 1);
      tick(5);
      do_reset();
      stall_bus = 0;
      run_cmd(CMD_READ, 32'h0);

      // pointer wrap
      run_cmd(CMD_SET_PTR, 32'hFFFF_FFFC);
      run_cmd(CMD_READ, 32'h0);
      run_cmd(CMD_READ, 32'h0);

      // random command mix
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 9))
            0, 1: begin
               if ($urandom_range(0, 3) == 0)
                  run_cmd(CMD_SET_PTR, 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
               else
                  run_cmd(CMD_SET_PTR, 32'h0000_1000 + 32'($urandom_range(0, 31)));
            end
            2, 3, 4: run_cmd(CMD_WRITE, $urandom);
            5, 6, 7: run_cmd(CMD_READ, 32'h0);
            8:       run_cmd(CMD_CLK, $urandom);
            default: begin
               do junk = 8'($urandom);
               while (junk == CMD_SET_PTR || junk == CMD_WRITE || junk == CMD_READ || junk == CMD_CLK);
               run_cmd(junk, 32'h0);
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
